// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU/imm/WB
// selects, FSM states, instruction classes and trap causes.
package cu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILL
  } cls_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cu_multicycle_if.sv
// Instruction/data memory handshake bundle between the control unit and memories.
interface cu_multicycle_if;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic        dmem_ready;
  logic        dmem_req;
  logic        MemRW;

  modport master (output imem_req, dmem_req, MemRW,
                  input  imem_rdata, imem_ready, dmem_ready);
  modport slave  (input  imem_req, dmem_req, MemRW,
                  output imem_rdata, imem_ready, dmem_ready);
endinterface

// File: rtl/cu_decode.sv
// Combinational instruction decode: instruction class, ALU op, immediate format
// and illegal-instruction flag from the opcode/funct fields of IR.
module cu_decode
  import cu_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter int IMMSEL_W = 3
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  output cls_t                cls,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [IMMSEL_W-1:0] immsel,
  output logic                illegal
);

  logic [3:0] alu;
  logic [2:0] imm;

  always_comb begin
    cls     = CLS_ILL;
    alu     = ALU_ADD;
    imm     = IMM_I;
    illegal = 1'b0;
    case (opcode)
      OP_R:    begin cls = CLS_R;    alu = alu_of_funct3(funct3, funct7b5); end
      // only SRAI honours bit 30 among the immediate forms
      OP_IALU: begin
        cls = CLS_IALU;
        alu = alu_of_funct3(funct3, funct7b5 && (funct3 == 3'b101));
      end
      OP_LOAD:  cls = CLS_LOAD;
      OP_STORE: begin cls = CLS_STORE; imm = IMM_S; end
      OP_BRANCH: begin
        cls     = CLS_BRANCH;
        imm     = IMM_B;
        illegal = (funct3[2:1] == 2'b01);
      end
      OP_JAL:   begin cls = CLS_JAL;   imm = IMM_J; end
      OP_JALR:  cls = CLS_JALR;
      OP_LUI:   begin cls = CLS_LUI;   imm = IMM_U; alu = ALU_PASSB; end
      OP_AUIPC: begin cls = CLS_AUIPC; imm = IMM_U; end
      default:  illegal = 1'b1;
    endcase
  end

  assign aluop  = ALUOP_W'(alu);
  assign immsel = IMMSEL_W'(imm);

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// ready handshakes, wait timeouts and a sticky trap.
module cu_multicycle
  import cu_pkg::*;
#(
  parameter int          ALUOP_W     = 4,
  parameter int          IMMSEL_W    = 3,
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [31:0] RESET_IR    = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst_n,
  cu_multicycle_if.master     bus,
  input  logic                BrEq,
  input  logic                BrLt,
  output logic [31:0]         ir,
  output logic                ir_we,
  output logic                pc_we,
  output logic                PCSel,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic [IMMSEL_W-1:0] ImmSel,
  output logic                ASel,
  output logic                BSel,
  output logic                BrUn,
  output logic                wEn,
  output logic [1:0]          WBSel,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_t              state;
  logic [7:0]          wait_cnt;
  cls_t                cls;
  logic [ALUOP_W-1:0]  dec_aluop;
  logic [IMMSEL_W-1:0] dec_immsel;
  logic                illegal;
  logic                taken;
  logic                timeout_hit;
  logic                is_store;
  logic                is_jump;

  cu_decode #(.ALUOP_W(ALUOP_W), .IMMSEL_W(IMMSEL_W)) u_decode (
    .opcode   (ir[6:0]),
    .funct3   (ir[14:12]),
    .funct7b5 (ir[30]),
    .cls      (cls),
    .aluop    (dec_aluop),
    .immsel   (dec_immsel),
    .illegal  (illegal)
  );

  assign is_store    = (cls == CLS_STORE);
  assign is_jump     = (cls == CLS_JAL) || (cls == CLS_JALR);
  assign timeout_hit = (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    case (ir[14:12])
      3'b000:         taken = BrEq;
      3'b001:         taken = !BrEq;
      3'b100, 3'b110: taken = BrLt;
      3'b101, 3'b111: taken = !BrLt;
      default:        taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ir         <= RESET_IR;
      wait_cnt   <= '0;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          wait_cnt <= '0;
        end
        FETCH: begin
          // a ready arriving on the last allowed cycle still wins over the timeout
          if (bus.imem_ready) begin
            ir    <= bus.imem_rdata;
            state <= DECODE;
          end else if (timeout_hit) begin
            trap       <= 1'b1;
            trap_cause <= CAUSE_IMEM_TO;
            state      <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (illegal) begin
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
            state      <= TRAP;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          wait_cnt <= '0;
          case (cls)
            CLS_LOAD, CLS_STORE: state <= MEM;
            CLS_BRANCH:          state <= FETCH;
            default:             state <= WB;
          endcase
        end
        MEM: begin
          if (bus.dmem_ready) begin
            state    <= is_store ? FETCH : WB;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            trap       <= 1'b1;
            trap_cause <= CAUSE_DMEM_TO;
            state      <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          state    <= FETCH;
          wait_cnt <= '0;
        end
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req = (state == FETCH);
  assign bus.dmem_req = (state == MEM);
  assign bus.MemRW    = (state == MEM) && is_store;
  assign ir_we        = (state == FETCH) && bus.imem_ready;

  // datapath selects are held from EXEC through MEM and WB
  always_comb begin
    pc_we  = 1'b0;
    PCSel  = 1'b0;
    ALUop  = '0;
    ImmSel = '0;
    ASel   = 1'b0;
    BSel   = 1'b0;
    BrUn   = 1'b0;
    wEn    = 1'b0;
    WBSel  = WB_MEM;
    if (state == EXEC || state == MEM || state == WB) begin
      ALUop  = dec_aluop;
      ImmSel = dec_immsel;
      ASel   = (cls == CLS_BRANCH) || (cls == CLS_JAL) || (cls == CLS_AUIPC);
      BSel   = (cls != CLS_R);
      BrUn   = (cls == CLS_BRANCH) && ir[13];
    end
    case (state)
      EXEC: begin
        if (cls == CLS_BRANCH) begin
          pc_we = 1'b1;
          PCSel = taken;
        end else if (is_jump) begin
          pc_we = 1'b1;
          PCSel = 1'b1;
        end
      end
      MEM: pc_we = is_store && bus.dmem_ready;
      WB: begin
        wEn   = 1'b1;
        pc_we = !is_jump;
        if (cls == CLS_LOAD) WBSel = WB_MEM;
        else if (is_jump)    WBSel = WB_PC4;
        else                 WBSel = WB_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// Randomised bench for cu_multicycle: a per-instruction trace model predicts every
// cycle's control vector, which is compared against the sampled DUT outputs.
module tb_cu_multicycle;

  localparam int TO = 16;

  typedef struct packed {
    logic       imem_req, dmem_req, memrw, ir_we, pc_we, pcsel;
    logic [3:0] aluop;
    logic [2:0] immsel;
    logic       asel, bsel, brun, wen;
    logic [1:0] wbsel;
    logic       trap;
    logic [1:0] cause;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    int          idly;
    int          ddly;
    bit          breq;
    bit          brlt;
  } ins_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        BrEq, BrLt;
  logic [31:0] ir;
  logic        ir_we, pc_we, PCSel, ASel, BSel, BrUn, wEn, trap;
  logic [3:0]  ALUop;
  logic [2:0]  ImmSel;
  logic [1:0]  WBSel, trap_cause;

  int   checks = 0;
  int   passes = 0;
  ins_t prog_q[$];
  vec_t exp_q[$];
  vec_t obs_q[$];

  cu_multicycle_if bus();

  cu_multicycle #(.ALUOP_W(4), .IMMSEL_W(3), .MEM_TIMEOUT(TO), .RESET_IR(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .BrEq(BrEq), .BrLt(BrLt),
    .ir(ir), .ir_we(ir_we), .pc_we(pc_we), .PCSel(PCSel), .ALUop(ALUop),
    .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn), .wEn(wEn),
    .WBSel(WBSel), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  function automatic vec_t cur_vec();
    vec_t v;
    v = '{bus.imem_req, bus.dmem_req, bus.MemRW, ir_we, pc_we, PCSel, ALUop, ImmSel,
          ASel, BSel, BrUn, wEn, WBSel, trap, trap_cause};
    return v;
  endfunction

  // ---------------- reference model ----------------
  // class codes: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, -1 illegal
  function automatic int cls_of(logic [31:0] w);
    case (w[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return (w[14:12] == 3'd2 || w[14:12] == 3'd3) ? -1 : 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      7'b0110111: return 7;
      7'b0010111: return 8;
      default:    return -1;
    endcase
  endfunction

  function automatic vec_t ctrl_of(logic [31:0] w);
    int   alu_tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int   f3 = int'(w[14:12]);
    int   c = cls_of(w);
    int   alu = 0;
    vec_t v = '0;
    v.bsel = (c != 0);
    if (c == 0 || c == 1) begin
      alu = alu_tbl[f3];
      if (w[30] && f3 == 5) alu = 7;
      if (c == 0 && w[30] && f3 == 0) alu = 1;
    end
    if (c == 7) alu = 10;
    v.aluop  = 4'(alu);
    v.immsel = (c == 3) ? 3'd1 : (c == 4) ? 3'd2 : (c == 7 || c == 8) ? 3'd3 : (c == 5) ? 3'd4 : 3'd0;
    v.asel   = (c == 4 || c == 5 || c == 8);
    v.brun   = (c == 4) && w[13];
    return v;
  endfunction

  function automatic vec_t trap_vec(int cause);
    vec_t v = '0;
    v.trap  = 1'b1;
    v.cause = 2'(cause);
    return v;
  endfunction

  function automatic void model_push(ins_t in);
    vec_t f = '0;
    vec_t e, m, x;
    int   c = cls_of(in.w);
    int   f3 = int'(in.w[14:12]);
    bit   tk;
    f.imem_req = 1'b1;
    for (int k = 0; k < ((in.idly >= TO) ? TO : in.idly); k++) exp_q.push_back(f);
    if (in.idly >= TO) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(trap_vec(2));
      return;
    end
    f.ir_we = 1'b1;
    exp_q.push_back(f);
    exp_q.push_back('0);
    if (c < 0) begin
      for (int k = 0; k < 5; k++) exp_q.push_back(trap_vec(1));
      return;
    end
    e = ctrl_of(in.w);
    tk = (f3 == 0) ? in.breq : (f3 == 1) ? !in.breq : (f3 == 4 || f3 == 6) ? in.brlt : !in.brlt;
    x = e;
    if (c == 4) begin x.pc_we = 1'b1; x.pcsel = tk; end
    if (c == 5 || c == 6) begin x.pc_we = 1'b1; x.pcsel = 1'b1; end
    exp_q.push_back(x);
    if (c == 4) return;
    if (c == 2 || c == 3) begin
      m = e;
      m.dmem_req = 1'b1;
      m.memrw = (c == 3);
      for (int k = 0; k < ((in.ddly >= TO) ? TO : in.ddly); k++) exp_q.push_back(m);
      if (in.ddly >= TO) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(trap_vec(3));
        return;
      end
      m.pc_we = (c == 3);
      exp_q.push_back(m);
      if (c == 3) return;
    end
    x = e;
    x.wen   = 1'b1;
    x.wbsel = (c == 2) ? 2'd0 : (c == 5 || c == 6) ? 2'd2 : 2'd1;
    x.pc_we = !(c == 5 || c == 6);
    exp_q.push_back(x);
  endfunction

  function automatic void add(logic [31:0] w, int idly, int ddly, bit breq, bit brlt);
    ins_t i;
    i = '{w, idly, ddly, breq, brlt};
    prog_q.push_back(i);
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic reset_dut();
    rst_n = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.imem_rdata = '0;
    BrEq = 1'b0; BrLt = 1'b0;
    prog_q.delete(); exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // plays prog_q as a memory model for exactly as many cycles as the model predicts
  task automatic run_prog();
    int pi = 0, cur = 0, icnt = 0, dcnt = 0;
    bit iacc, dacc;
    foreach (prog_q[j]) model_push(prog_q[j]);
    for (int k = 0; k < exp_q.size(); k++) begin
      bus.imem_rdata = (pi < prog_q.size()) ? prog_q[pi].w : 32'h00000013;
      bus.imem_ready = bus.imem_req && (pi < prog_q.size()) && (icnt >= prog_q[pi].idly);
      bus.dmem_ready = bus.dmem_req && (dcnt >= prog_q[cur].ddly);
      BrEq = prog_q[cur].breq;
      BrLt = prog_q[cur].brlt;
      #1;
      obs_q.push_back(cur_vec());
      iacc = bus.imem_req && bus.imem_ready;
      dacc = bus.dmem_req && bus.dmem_ready;
      @(posedge clk);
      if (iacc) begin cur = pi; pi++; icnt = 0; end
      else if (bus.imem_req) icnt++;
      if (dacc) dcnt = 0;
      else if (bus.dmem_req) dcnt++;
      #1;
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.imem_rdata = '0;
    BrEq = 1'b0; BrLt = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (cur_vec() !== vec_t'(0)) $display("FAIL reset_outputs got=%h exp=%h", cur_vec(), vec_t'(0));
    else passes++;
    checks++;
    if (ir !== 32'h00000013) $display("FAIL reset_ir got=%h exp=%h", ir, 32'h00000013);
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (cur_vec() !== vec_t'(0)) $display("FAIL idle_outputs got=%h exp=%h", cur_vec(), vec_t'(0));
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (bus.imem_req !== 1'b1) $display("FAIL idle_to_fetch got=%b exp=1", bus.imem_req);
    else passes++;
  endtask

  task automatic test_alu();
    logic [31:0] w;
    reset_dut();
    add(32'h002081B3, 0, 0, 0, 0);
    add(32'h402081B3, 1, 0, 0, 0);
    add(32'h4020D193, 0, 0, 0, 0);
    add(32'h4030C193, 2, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      w = $urandom;
      w[6:0] = n[0] ? 7'b0110011 : 7'b0010011;
      add(w, $urandom_range(0, 3), 0, 0, 0);
    end
    run_prog();
    checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL alu_len got=%0d exp=%0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL alu cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (ir !== prog_q[prog_q.size()-1].w) $display("FAIL alu_ir got=%h exp=%h", ir, prog_q[prog_q.size()-1].w);
    else passes++;
  endtask

  task automatic test_load_store();
    logic [31:0] w;
    reset_dut();
    add(32'h0000A183, 0, 3, 0, 0);
    add(32'h0020A023, 0, 0, 0, 0);
    for (int n = 0; n < 12; n++) begin
      w = $urandom;
      w[6:0] = n[0] ? 7'b0100011 : 7'b0000011;
      add(w, $urandom_range(0, 2), $urandom_range(0, 5), 0, 0);
    end
    add(32'h0000A183, 0, TO - 1, 0, 0);
    add(32'h0020A023, 0, TO, 0, 0);
    run_prog();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL ldst cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_branch();
    int          f3s[6] = '{0, 1, 4, 5, 6, 7};
    logic [31:0] w;
    reset_dut();
    add(32'h00209463, 0, 0, 0, 0);
    add(32'h00209463, 0, 0, 1, 0);
    add(32'h0020E463, 1, 0, 0, 1);
    for (int n = 0; n < 16; n++) begin
      w = $urandom;
      w[6:0] = 7'b1100011;
      w[14:12] = 3'(f3s[$urandom_range(0, 5)]);
      add(w, $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_prog();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL branch cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_jump_upper();
    logic [6:0]  ops[4] = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [31:0] w;
    reset_dut();
    for (int n = 0; n < 12; n++) begin
      w = $urandom;
      w[6:0] = ops[n % 4];
      add(w, $urandom_range(0, 3), 0, 0, 0);
    end
    add(32'h0000207F, 0, 0, 0, 0);
    run_prog();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL jump_illegal cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_illegal_random();
    logic [31:0] w;
    for (int n = 0; n < 4; n++) begin
      reset_dut();
      w = 32'h0000207F;
      for (int t = 0; t < 200; t++) begin
        w = $urandom;
        if (n == 0) w[6:0] = 7'b1100011;
        if (cls_of(w) < 0) break;
      end
      add(w, $urandom_range(0, 2), 0, 0, 0);
      run_prog();
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL illegal%0d cyc%0d got=%h exp=%h", n, i, obs_q[i], exp_q[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    add(32'h002081B3, TO - 1, 0, 0, 0);
    add(32'h002081B3, TO, 0, 0, 0);
    run_prog();
    foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL timeout cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    bus.imem_rdata = 32'h002081B3;
    bus.imem_ready = 1'b1;
    @(posedge clk); #1;
    bus.imem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (wEn !== 1'b1) $display("FAIL wb_before_reset got=%b exp=1", wEn);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cur_vec() !== vec_t'(0)) $display("FAIL async_reset_outputs got=%h exp=%h", cur_vec(), vec_t'(0));
    else passes++;
    checks++;
    if (ir !== 32'h00000013) $display("FAIL async_reset_ir got=%h exp=%h", ir, 32'h00000013);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.imem_req !== 1'b1 || wEn !== 1'b0) $display("FAIL restart_fetch got=%b%b exp=10", bus.imem_req, wEn);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_jump_upper();
    test_illegal_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
